shift_load_seq: RTL and testbench

Command sequencer that sits directly upstream of the parallel-load/bidirectional shift register. It accepts one command (word, direction, shift count), drives the register's `mode`, `direction` and `data_in` inputs to load the word and shift it the requested number of steps, then freezes the register by reloading a locally tracked shadow copy. `done` pulses when the register holds the final value.

---
 rtl/shift_load_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_shift_load_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_load_seq.sv
`timescale 1ns/1ps
// shift_load_seq
// ---------------------------------------------------------------------------
// Command sequencer for a parallel-load / bidirectional shift register that
// has no hold mode. One command (word, direction, shift count) is turned into
// one load cycle followed by N shift cycles. Outside a command the register is
// kept frozen by reloading a locally tracked shadow copy of its contents.
//
// Optional feature (compile-time macro SEQ_QUEUE_EN):
//   Adds a one-entry command buffer, so a command can be accepted while
//   another one executes. The buffered command starts on the completion edge
//   of the running one, so there is no idle cycle between them.
//
// Parameters:
//   width      data word width (must match the downstream register)
//   cnt_width  width of the shift-count field
//
// Ports:
//   clk         rising-edge clock, shared with the downstream register
//   rst_n       asynchronous active-low reset
//   start       command strobe
//   cmd_data    word to load
//   cmd_dir     shift direction, 0 = left, 1 = right
//   cmd_shifts  number of shift steps (0 allowed, >= width gives 0)
//   cmd_ready   a command is accepted at this edge if start = 1
//   busy        a command is executing
//   done        one-cycle pulse when the register holds the final value
//   mode        to register: 0 = load, 1 = shift
//   direction   to register: 0 = left, 1 = right
//   data_in     to register's parallel input
// ---------------------------------------------------------------------------
module shift_load_seq #(
    parameter int width     = 16,
    parameter int cnt_width = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [width-1:0]     cmd_data,
    input  logic                 cmd_dir,
    input  logic [cnt_width-1:0] cmd_shifts,
    output logic                 cmd_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 mode,
    output logic                 direction,
    output logic [width-1:0]     data_in
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

    // One shift step with zero fill, identical to what the register does.
    function automatic logic [width-1:0] shift_once(input logic [width-1:0] v,
                                                    input logic dir);
        if (dir)
            return {1'b0, v[width-1:1]};
        else
            return {v[width-2:0], 1'b0};
    endfunction

    logic [1:0]           state_reg,     state_next;
    logic [cnt_width-1:0] count_reg,     count_next;
    logic [width-1:0]     shadow_reg,    shadow_next;
    logic                 mode_reg,      mode_next;
    logic                 direction_reg, direction_next;
    logic [width-1:0]     data_in_reg,   data_in_next;
    logic                 busy_reg,      busy_next;
    logic                 done_reg,      done_next;
    logic                 cmd_ready_reg, cmd_ready_next;

`ifdef SEQ_QUEUE_EN
    logic                 buf_valid_reg,  buf_valid_next;
    logic [width-1:0]     buf_data_reg,   buf_data_next;
    logic                 buf_dir_reg,    buf_dir_next;
    logic [cnt_width-1:0] buf_shifts_reg, buf_shifts_next;
    logic                 launch_buf;
`endif

    logic             accept;
    logic             finish;
    logic             launch_cmd;
    logic [width-1:0] shifted;

    assign accept  = start & cmd_ready_reg;
    // The shadow always shifts in the direction latched for the running command.
    assign shifted = shift_once(shadow_reg, direction_reg);

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        shadow_next    = shadow_reg;
        direction_next = direction_reg;
        mode_next      = 1'b0;
        data_in_next   = shadow_reg;   // default: freeze register by reloading it
        busy_next      = 1'b0;
        done_next      = 1'b0;
        finish         = 1'b0;
        launch_cmd     = 1'b0;
`ifdef SEQ_QUEUE_EN
        launch_buf      = 1'b0;
        buf_valid_next  = buf_valid_reg;
        buf_data_next   = buf_data_reg;
        buf_dir_next    = buf_dir_reg;
        buf_shifts_next = buf_shifts_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (accept)
                    launch_cmd = 1'b1;
            end
            ST_LOAD: begin
                if (count_reg == '0) begin
                    finish = 1'b1;   // data_in stays at shadow (= loaded word)
                end else begin
                    state_next = ST_SHIFT;
                    mode_next  = 1'b1;
                    busy_next  = 1'b1;
                end
            end
            ST_SHIFT: begin
                // The register shifts at this same edge, so the shadow
                // follows it step for step.
                shadow_next = shifted;
                count_next  = count_reg - CNT_ONE;
                if (count_reg == CNT_ONE) begin
                    finish       = 1'b1;
                    data_in_next = shifted;
                end else begin
                    mode_next = 1'b1;
                    busy_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (finish) begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
`ifdef SEQ_QUEUE_EN
            // The register already holds the final value after this edge,
            // so the next command may start loading right away.
            if (buf_valid_reg)
                launch_buf = 1'b1;
            else if (accept)
                launch_cmd = 1'b1;
`endif
        end

        if (launch_cmd) begin
            state_next     = ST_LOAD;
            mode_next      = 1'b0;
            data_in_next   = cmd_data;
            shadow_next    = cmd_data;
            direction_next = cmd_dir;
            count_next     = cmd_shifts;
            busy_next      = 1'b1;
        end

`ifdef SEQ_QUEUE_EN
        if (launch_buf) begin
            state_next     = ST_LOAD;
            mode_next      = 1'b0;
            data_in_next   = buf_data_reg;
            shadow_next    = buf_data_reg;
            direction_next = buf_dir_reg;
            count_next     = buf_shifts_reg;
            busy_next      = 1'b1;
            buf_valid_next = 1'b0;
        end
        // A command accepted while one is running waits in the buffer.
        if (accept && !launch_cmd) begin
            buf_valid_next  = 1'b1;
            buf_data_next   = cmd_data;
            buf_dir_next    = cmd_dir;
            buf_shifts_next = cmd_shifts;
        end
        cmd_ready_next = !buf_valid_next;
`else
        cmd_ready_next = !busy_next;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            shadow_reg    <= '0;
            mode_reg      <= 1'b0;
            direction_reg <= 1'b0;
            data_in_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            cmd_ready_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            shadow_reg    <= shadow_next;
            mode_reg      <= mode_next;
            direction_reg <= direction_next;
            data_in_reg   <= data_in_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            cmd_ready_reg <= cmd_ready_next;
        end
    end

`ifdef SEQ_QUEUE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_reg  <= 1'b0;
            buf_data_reg   <= '0;
            buf_dir_reg    <= 1'b0;
            buf_shifts_reg <= '0;
        end else begin
            buf_valid_reg  <= buf_valid_next;
            buf_data_reg   <= buf_data_next;
            buf_dir_reg    <= buf_dir_next;
            buf_shifts_reg <= buf_shifts_next;
        end
    end
`endif

    assign cmd_ready = cmd_ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign mode      = mode_reg;
    assign direction = direction_reg;
    assign data_in   = data_in_reg;

endmodule

// File: tb/tb_shift_load_seq.sv
`timescale 1ns/1ps
// Testbench for shift_load_seq: drives directed commands, models the
// downstream load/shift register and checks sequencer outputs and register
// contents against hand-computed values.
module tb_shift_load_seq;

    localparam int W  = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  cmd_data = '0;
    logic          cmd_dir = 1'b0;
    logic [CW-1:0] cmd_shifts = '0;
    logic          cmd_ready, busy, done, mode, direction;
    logic [W-1:0]  data_in;
    logic [W-1:0]  reg_q;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_load_seq #(.width(W), .cnt_width(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cmd_data   (cmd_data),
        .cmd_dir    (cmd_dir),
        .cmd_shifts (cmd_shifts),
        .cmd_ready  (cmd_ready),
        .busy       (busy),
        .done       (done),
        .mode       (mode),
        .direction  (direction),
        .data_in    (data_in)
    );

    // Downstream register: load when mode=0, shift one bit with zero fill when mode=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            reg_q <= '0;
        else if (!mode)
            reg_q <= data_in;
        else if (direction)
            reg_q <= {1'b0, reg_q[W-1:1]};
        else
            reg_q <= {reg_q[W-2:0], 1'b0};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command once cmd_ready is high; returns just after the accepting edge.
    task automatic issue(input string tag, input logic [W-1:0] d, input logic dir,
                         input logic [CW-1:0] n);
        int g = 0;
        while (!cmd_ready && g < 50) begin
            tick();
            g++;
        end
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        start      = 1'b1;
        cmd_data   = d;
        cmd_dir    = dir;
        cmd_shifts = n;
        tick();
        start = 1'b0;
        check({tag, "_load_busy"}, 32'(busy), 32'd1);
        check({tag, "_load_mode"}, 32'(mode), 32'd0);
        check({tag, "_load_data"}, 32'(data_in), 32'(d));
        check({tag, "_load_dir"},  32'(direction), 32'(dir));
`ifndef SEQ_QUEUE_EN
        check({tag, "_load_notready"}, 32'(cmd_ready), 32'd0);
`endif
    endtask

    // Wait for done; counts cycles and mode-high cycles. poke >= 0 raises a
    // stray start at that cycle.
    task automatic wait_done(input string tag, input int n, input logic [W-1:0] exp,
                             input int poke);
        int cyc = 0;
        int mc  = 0;
        while (cyc < 100) begin
            tick();
            cyc++;
            start = 1'b0;
            if (mode) mc++;
            if (done) break;
            if (cyc == poke) begin
                check({tag, "_busy_notready"}, 32'(cmd_ready), 32'd0);
                start      = 1'b1;
                cmd_data   = 16'hAAAA;
                cmd_dir    = 1'b0;
                cmd_shifts = 5'd1;
            end
        end
        check({tag, "_cycles"},  32'(cyc), 32'(n + 1));
        check({tag, "_modecnt"}, 32'(mc), 32'(n));
        check({tag, "_busy"},    32'(busy), 32'd0);
        check({tag, "_mode"},    32'(mode), 32'd0);
        check({tag, "_data_in"}, 32'(data_in), 32'(exp));
        check({tag, "_reg"},     32'(reg_q), 32'(exp));
        $display("txn %s: shifts=%0d cycles=%0d mode_cycles=%0d reg=%04h", tag, n, cyc, mc, reg_q);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_mode",  32'(mode), 32'd0);
        check("rst_dir",   32'(direction), 32'd0);
        check("rst_data",  32'(data_in), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // 8001 left 3 -> 0008, then hold for 10 cycles
        issue("t_8001", 16'h8001, 1'b0, 5'd3);
        wait_done("t_8001", 3, 16'h0008, -1);
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || mode) dn++;
        end
        check("hold_events", 32'(dn), 32'd0);
        check("hold_reg",    32'(reg_q), 32'h0008);
        check("hold_data",   32'(data_in), 32'h0008);

        // 00F0 right 4 -> 000F
        issue("t_00f0", 16'h00F0, 1'b1, 5'd4);
        wait_done("t_00f0", 4, 16'h000F, -1);
        check("t_00f0_dirhold", 32'(direction), 32'd1);

        // zero shifts
        issue("t_1234", 16'h1234, 1'b0, 5'd0);
        wait_done("t_1234", 0, 16'h1234, -1);

        // FFFF right 20 -> 0
`ifndef SEQ_QUEUE_EN
        issue("t_ffff", 16'hFFFF, 1'b1, 5'd20);
        wait_done("t_ffff", 20, 16'h0000, 3);
        // start in the done cycle runs back-to-back (issue checks busy after that edge)
        issue("t_b2b", 16'h0003, 1'b0, 5'd2);
        wait_done("t_b2b", 2, 16'h000C, -1);
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy) dn++;
        end
        check("ignored_start_busy", 32'(dn), 32'd0);
        check("ignored_start_reg",  32'(reg_q), 32'h000C);
`else
        issue("t_ffff", 16'hFFFF, 1'b1, 5'd20);
        wait_done("t_ffff", 20, 16'h0000, -1);
        begin
            int first_done = -1;
            int second_done = -1;
            int ndone = 0;
            int busy_at_first = 0;
            issue("q_a", 16'h00F0, 1'b1, 5'd4);
            start      = 1'b1;
            cmd_data   = 16'h0101;
            cmd_dir    = 1'b0;
            cmd_shifts = 5'd1;
            tick();
            start = 1'b0;
            check("q_ready_drop", 32'(cmd_ready), 32'd0);
            for (int i = 1; i <= 20; i++) begin
                tick();
                if (done) begin
                    ndone++;
                    if (first_done < 0) begin
                        first_done = i;
                        busy_at_first = int'(busy);
                    end else begin
                        second_done = i;
                    end
                end
            end
            check("q_ndone",      32'(ndone), 32'd2);
            check("q_busy_first", 32'(busy_at_first), 32'd1);
            check("q_gap",        32'(second_done - first_done), 32'd2);
            check("q_reg",        32'(reg_q), 32'h0202);
            $display("txn q: done_pulses=%0d reg=%04h", ndone, reg_q);
        end
`endif

        // Reset during SHIFT
        issue("t_rst", 16'hFFFF, 1'b0, 5'd10);
        tick();
        tick();
        check("rst_mid_mode_before", 32'(mode), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_mode",  32'(mode), 32'd0);
        check("rst_mid_busy",  32'(busy), 32'd0);
        check("rst_mid_data",  32'(data_in), 32'd0);
        check("rst_mid_done",  32'(done), 32'd0);
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);
        check("rst_mid_dir",   32'(direction), 32'd0);
        dn = 0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done || busy) dn++;
        end
        check("rst_mid_no_done", 32'(dn), 32'd0);
        $display("txn t_rst: reset mid-command, post-reset events=%0d", dn);

        // Still operational after reset
        issue("t_post", 16'h0005, 1'b1, 5'd1);
        wait_done("t_post", 1, 16'h0002, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
